// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between NREQ requesters.
// Ports: rq_* core-side request/ack buses; data_*/addr/c_re/c_we/m_*ack memory side.
module mem_port_arbiter #(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        rq_re,
    input  logic [NREQ-1:0]        rq_we,
    input  logic [NREQ*LEN_W-1:0]  rq_len,
    input  logic [NREQ*ADDR_W-1:0] rq_raddr,
    input  logic [NREQ*ADDR_W-1:0] rq_waddr,
    input  logic [NREQ*DATA_W-1:0] rq_wdata,
    output logic [DATA_W-1:0]      rq_rdata,
    output logic [NREQ-1:0]        rq_rack,
    output logic [NREQ-1:0]        rq_wack,
    output logic [NREQ-1:0]        rq_err,
    input  logic [DATA_W-1:0]      data_in,
    output logic [DATA_W-1:0]      data_out,
    output logic [ADDR_W-1:0]      read_addr,
    output logic [ADDR_W-1:0]      write_addr,
    output logic [LEN_W-1:0]       m_len,
    output logic                   c_re,
    output logic                   c_we,
    input  logic                   m_rack,
    input  logic                   m_wack
);

    localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [GW-1:0]   ptr;
    logic [GW-1:0]   g;
    logic [GW-1:0]   win;
    logic            found;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] cand;
    logic            ack_ok;
    logic            tmo;
    logic            busy;
    int              j;

    assign cand   = rq_re | rq_we;
    assign busy   = (state == RD) || (state == WR);
    assign ack_ok = ((state == RD) && m_rack) || ((state == WR) && m_wack);
    // Counter holds cycles already spent; the TIMEOUT-th enabled cycle aborts.
    assign tmo    = (TIMEOUT != 0) && busy && !ack_ok && (cnt == CW'(TLIM));

    // Descending scan so the candidate closest to ptr is written last.
    always_comb begin
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (cand[j]) begin
                found = 1'b1;
                win   = GW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (found) state_nxt = rq_re[win] ? RD : WR;
            RD, WR: if (ack_ok || tmo) state_nxt = ACK;
            ACK: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr        <= '0;
            g          <= '0;
            cnt        <= '0;
            c_re       <= 1'b0;
            c_we       <= 1'b0;
            read_addr  <= '0;
            write_addr <= '0;
            data_out   <= '0;
            m_len      <= '0;
            rq_rdata   <= '0;
            rq_rack    <= '0;
            rq_wack    <= '0;
            rq_err     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        g     <= win;
                        cnt   <= '0;
                        m_len <= rq_len[win*LEN_W +: LEN_W];
                        if (rq_re[win]) begin
                            c_re      <= 1'b1;
                            read_addr <= rq_raddr[win*ADDR_W +: ADDR_W];
                        end else begin
                            c_we       <= 1'b1;
                            write_addr <= rq_waddr[win*ADDR_W +: ADDR_W];
                            data_out   <= rq_wdata[win*DATA_W +: DATA_W];
                        end
                    end
                end
                RD, WR: begin
                    if (ack_ok || tmo) begin
                        c_re <= 1'b0;
                        c_we <= 1'b0;
                        if (state == RD) rq_rack <= NREQ'(1) << g;
                        else             rq_wack <= NREQ'(1) << g;
                        if (tmo) begin
                            rq_err   <= NREQ'(1) << g;
                            rq_rdata <= '0;
                        end else if (state == RD) begin
                            rq_rdata <= data_in;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK: begin
                    rq_rack <= '0;
                    rq_wack <= '0;
                    rq_err  <= '0;
                    ptr     <= (g == GW'(NREQ - 1)) ? '0 : g + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Directed steps followed by randomized transactions against a reference model.
module tb_mem_port_arbiter;

    localparam int N    = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LW   = 2;
    localparam int TOUT = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    rq_re = '0;
    logic [N-1:0]    rq_we = '0;
    logic [N*LW-1:0] rq_len = '0;
    logic [N*AW-1:0] rq_raddr = '0;
    logic [N*AW-1:0] rq_waddr = '0;
    logic [N*DW-1:0] rq_wdata = '0;
    logic [DW-1:0]   rq_rdata;
    logic [N-1:0]    rq_rack;
    logic [N-1:0]    rq_wack;
    logic [N-1:0]    rq_err;
    logic [DW-1:0]   data_in = '0;
    logic [DW-1:0]   data_out;
    logic [AW-1:0]   read_addr;
    logic [AW-1:0]   write_addr;
    logic [LW-1:0]   m_len;
    logic            c_re;
    logic            c_we;
    logic            m_rack = 1'b0;
    logic            m_wack = 1'b0;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int ptr_m  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NREQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .rq_re(rq_re), .rq_we(rq_we), .rq_len(rq_len),
        .rq_raddr(rq_raddr), .rq_waddr(rq_waddr), .rq_wdata(rq_wdata),
        .rq_rdata(rq_rdata), .rq_rack(rq_rack), .rq_wack(rq_wack),
        .rq_err(rq_err), .data_in(data_in), .data_out(data_out),
        .read_addr(read_addr), .write_addr(write_addr), .m_len(m_len),
        .c_re(c_re), .c_we(c_we), .m_rack(m_rack), .m_wack(m_wack)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requester at or after p, wrapping.
    function automatic int pick(input logic [N-1:0] re,
                                input logic [N-1:0] we, input int p);
        for (int k = 0; k < N; k++)
            if (re[(p + k) % N] || we[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    task automatic wait_en(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(c_re || c_we) && cyc < 10);
        chk("grant_seen", 64'(c_re || c_we), 64'd1);
    endtask

    // Memory side: ack on enabled cycle dly+1, random wrong-type acks otherwise.
    task automatic serve(input int dly, input logic [DW-1:0] d, input bit give,
                         output logic [N-1:0] rk, output logic [N-1:0] wk,
                         output logic [N-1:0] er, output logic [DW-1:0] rdat,
                         output int ncyc);
        bit rd;
        rd   = c_re;
        ncyc = 0;
        while ((c_re || c_we) && ncyc < 20) begin
            ncyc++;
            if (give && ncyc == dly + 1) begin
                if (rd) begin
                    m_rack  = 1'b1;
                    data_in = d;
                end else begin
                    m_wack = 1'b1;
                end
            end else if ($urandom_range(0, 1) == 1) begin
                if (rd) m_wack = 1'b1;
                else    m_rack = 1'b1;
            end
            @(negedge clk);
            m_rack  = 1'b0;
            m_wack  = 1'b0;
            data_in = $urandom;
        end
        rk   = rq_rack;
        wk   = rq_wack;
        er   = rq_err;
        rdat = rq_rdata;
    endtask

    task automatic txn(input string tag, input int dly, input bit give);
        int           w;
        int           cyc;
        int           ncyc;
        bit           exp_rd;
        logic [N-1:0] oh;
        logic [N-1:0] rk;
        logic [N-1:0] wk;
        logic [N-1:0] er;
        logic [DW-1:0] rdat;
        logic [DW-1:0] d;
        w      = pick(rq_re, rq_we, ptr_m);
        exp_rd = rq_re[w];
        oh     = N'(1) << w;
        wait_en(cyc);
        chk({tag, "_c_re"}, 64'(c_re), 64'(exp_rd));
        chk({tag, "_c_we"}, 64'(c_we), 64'(!exp_rd));
        chk({tag, "_len"}, 64'(m_len), 64'(rq_len[w*LW +: LW]));
        if (exp_rd) begin
            chk({tag, "_raddr"}, 64'(read_addr), 64'(rq_raddr[w*AW +: AW]));
        end else begin
            chk({tag, "_waddr"}, 64'(write_addr), 64'(rq_waddr[w*AW +: AW]));
            chk({tag, "_wdata"}, 64'(data_out), 64'(rq_wdata[w*DW +: DW]));
        end
        d = $urandom;
        serve(dly, d, give, rk, wk, er, rdat, ncyc);
        chk({tag, "_rack"}, 64'(rk), exp_rd ? 64'(oh) : 64'd0);
        chk({tag, "_wack"}, 64'(wk), exp_rd ? 64'd0 : 64'(oh));
        chk({tag, "_err"}, 64'(er), give ? 64'd0 : 64'(oh));
        if (!give) chk({tag, "_tmo_len"}, 64'(ncyc), 64'(TOUT));
        if (exp_rd) chk({tag, "_rdata"}, 64'(rdat), give ? 64'(d) : 64'd0);
        ptr_m = (w + 1) % N;
    endtask

    initial begin
        int           cyc;
        int           ncyc;
        logic [N-1:0] rk;
        logic [N-1:0] wk;
        logic [N-1:0] er;
        logic [DW-1:0] rdat;

        repeat (2) @(negedge clk);
        chk("rst_c_re", 64'(c_re), 64'd0);
        chk("rst_c_we", 64'(c_we), 64'd0);
        chk("rst_acks", 64'({rq_rack, rq_wack, rq_err}), 64'd0);
        chk("rst_bus", 64'({read_addr, write_addr}), 64'd0);
        chk("rst_data", 64'({data_out, rq_rdata}), 64'd0);
        chk("rst_len", 64'(m_len), 64'd0);
        rst    = 1'b1;
        m_rack = 1'b1;
        m_wack = 1'b1;
        @(negedge clk);
        m_rack = 1'b0;
        m_wack = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_en", 64'({c_re, c_we}), 64'd0);
        chk("idle_acks", 64'({rq_rack, rq_wack, rq_err}), 64'd0);

        rq_raddr[1*AW +: AW] = 32'h100;
        rq_re = 3'b010;
        wait_en(cyc);
        chk("rd1_latency", 64'(cyc), 64'd1);
        chk("rd1_raddr", 64'(read_addr), 64'h100);
        serve(2, 32'hDEADBEEF, 1'b1, rk, wk, er, rdat, ncyc);
        chk("rd1_en_cycles", 64'(ncyc), 64'd3);
        chk("rd1_rack", 64'(rk), 64'b010);
        chk("rd1_rdata", 64'(rdat), 64'hDEADBEEF);
        rq_re = '0;
        @(negedge clk);
        chk("rd1_pulse_one", 64'(rq_rack), 64'd0);
        ptr_m = 2;

        rq_raddr[0 +: AW] = 32'h200;
        rq_re = 3'b001;
        wait_en(cyc);
        chk("mid_rst_pre", 64'(c_re), 64'd1);
        rq_re = '0;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_c_re", 64'(c_re), 64'd0);
        chk("mid_rst_addr", 64'(read_addr), 64'd0);
        chk("mid_rst_rdata", 64'(rq_rdata), 64'd0);
        @(negedge clk);
        chk("mid_rst_noack", 64'({rq_rack, rq_wack, rq_err}), 64'd0);
        rst   = 1'b1;
        ptr_m = 0;

        for (int i = 0; i < N; i++) rq_raddr[i*AW +: AW] = 32'h1000 + 32'(i * 16);
        rq_re = 3'b111;
        for (int i = 0; i < 6; i++) begin
            chk("rr_order_model", 64'(pick(rq_re, rq_we, ptr_m)), 64'(i % N));
            txn("rr", 0, 1'b1);
        end
        rq_re = '0;

        rq_raddr[2*AW +: AW] = 32'h40;
        rq_waddr[2*AW +: AW] = 32'h44;
        rq_wdata[2*DW +: DW] = 32'h55;
        rq_re = 3'b100;
        rq_we = 3'b100;
        txn("both_rd", 1, 1'b1);
        chk("both_rd_addr", 64'(read_addr), 64'h40);
        rq_re = '0;
        txn("both_wr", 1, 1'b1);
        chk("both_wr_addr", 64'(write_addr), 64'h44);
        chk("both_wr_data", 64'(data_out), 64'h55);
        rq_we = '0;

        rq_waddr[0 +: AW] = 32'h300;
        rq_wdata[0 +: DW] = 32'h77;
        rq_we = 3'b001;
        txn("tmo", 0, 1'b0);
        rq_we = '0;
        rq_re = 3'b010;
        txn("after_tmo", 0, 1'b1);
        rq_re = '0;

        rq_raddr[0 +: AW] = 32'h500;
        rq_re = 3'b001;
        wait_en(cyc);
        rq_re = '0;
        rq_raddr[0 +: AW] = 32'h999;
        @(negedge clk);
        chk("drop_addr", 64'(read_addr), 64'h500);
        chk("drop_en", 64'(c_re), 64'd1);
        serve(1, 32'h1234, 1'b1, rk, wk, er, rdat, ncyc);
        chk("drop_rack", 64'(rk), 64'b001);
        chk("drop_rdata", 64'(rdat), 64'h1234);
        ptr_m = 1;

        for (int it = 0; it < 30; it++) begin
            rq_re = N'($urandom_range(0, 7));
            rq_we = N'($urandom_range(0, 7));
            if ((rq_re | rq_we) == '0) rq_re = N'($urandom_range(1, 7));
            for (int i = 0; i < N; i++) begin
                rq_raddr[i*AW +: AW] = $urandom;
                rq_waddr[i*AW +: AW] = $urandom;
                rq_wdata[i*DW +: DW] = $urandom;
                rq_len[i*LW +: LW]   = LW'($urandom_range(0, 3));
            end
            txn("rnd", $urandom_range(0, 2), $urandom_range(0, 7) != 0);
            rq_re = '0;
            rq_we = '0;
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port (data_in/data_out, read_addr/write_addr, c_re/c_we, m_rack/m_wack) between NREQ core-side requesters, e.g. instruction fetch, data load and data store of one or more cpu_core instances.
- Sits between the core-side request buses and the memory controller pins at the riscv_cpu top level.
- Serialises requests: one memory transaction in flight at a time.
- Uses round-robin arbitration and a per-transaction ack watchdog.

Parameters:
NREQ, 3, number of requesters (1..8)
ADDR_W, 32, address width
DATA_W, 32, data width
LEN_W, 2, access length code width (passed through unmodified)
TIMEOUT, 255, cycles to wait for memory ack before aborting; 0 disables the watchdog

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
rq_re  in  NREQ  per-requester read request, level, held until ack
rq_we  in  NREQ  per-requester write request, level, held until ack
rq_len  in  NREQ*LEN_W  per-requester length code, requester i at bits [i*LEN_W +: LEN_W]
rq_raddr  in  NREQ*ADDR_W  per-requester read address
rq_waddr  in  NREQ*ADDR_W  per-requester write address
rq_wdata  in  NREQ*DATA_W  per-requester write data
rq_rdata  out  DATA_W  read data, shared bus, valid only while an rq_rack bit is high
rq_rack  out  NREQ  one-hot read-done pulse
rq_wack  out  NREQ  one-hot write-done pulse
rq_err  out  NREQ  one-hot timeout pulse, coincident with the rack/wack pulse of the aborted transaction
data_in  in  DATA_W  memory read data, valid with m_rack
data_out  out  DATA_W  memory write data
read_addr  out  ADDR_W  memory read address
write_addr  out  ADDR_W  memory write address
m_len  out  LEN_W  length code of the current transaction
c_re  out  1  memory read enable
c_we  out  1  memory write enable
m_rack  in  1  memory read acknowledge, single cycle
m_wack  in  1  memory write acknowledge, single cycle

Behaviour:
- Reset (rst low, asynchronous) clears every output, including all address and data registers, to 0.
  - State goes to IDLE; round-robin pointer goes to 0; watchdog counter goes to 0.
  - Reset mid-transaction drops c_re/c_we immediately. No ack is issued.
- All outputs are registered.
- States: IDLE, RD, WR, ACK.
- IDLE:
  - Candidates are requesters with rq_re or rq_we high.
  - The winner is the first candidate at or after the pointer, searching upward modulo NREQ.
  - If the winner has both rq_re and rq_we high, the read is served first.
  - On the next edge the arbiter latches the winner's index, address, len and wdata (for writes), sets c_re→RD or c_we→WR, and clears the watchdog.
  - With no candidate, the arbiter stays in IDLE.
- RD/WR:
  - Enable and latched outputs stay stable and are unaffected by any change on the rq_* inputs.
  - Watchdog counter increments each cycle.
  - On m_rack in RD (or m_wack in WR): drop c_re/c_we, register data_in into rq_rdata (RD only), pulse rq_rack[g] or rq_wack[g], go to ACK.
  - An ack of the wrong type is ignored.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT with no ack: same exit, plus rq_err[g] pulse; rq_rdata = 0.
- ACK:
  - Lasts exactly one cycle; ack pulses are high only in this cycle.
  - Pointer ← g+1 mod NREQ. Next state is IDLE.
  - The requester must drop the served request by the edge ending ACK; otherwise it is re-arbitrated as a new request.
- Latency: request sampled at edge 0 → c_re high after edge 0. If m_rack arrives in cycle k, rq_rack is high in cycle k+1.
- Minimum back-to-back cost per transaction: 1 (IDLE) + 1 (memory ack earliest) + 1 (ACK) = 3 cycles.
- Requester dropping its request mid-transaction: the transaction still completes and the ack still pulses.
- m_rack/m_wack asserted while in IDLE or ACK: ignored.

Test Plan:
- Reset release, no requests → all outputs 0, c_re=c_we=0 indefinitely; assert rst low mid-RD → c_re falls with no clock edge, no ack pulse.
- Single read, req 1, raddr=0x100, memory acks 2 cycles after c_re with data 0xDEADBEEF → read_addr=0x100, rq_rack=3'b010 for exactly one cycle, rq_rdata=0xDEADBEEF.
- All 3 requesters reading continuously, immediate acks → grant order 0,1,2,0,1,2; each ack pulse one cycle; no requester served twice in a row.
- Req 2 asserts re and we together (raddr=0x40, waddr=0x44, wdata=0x55) → read at 0x40 served first, then write to 0x44 with data_out=0x55.
- TIMEOUT=4, memory never acks a write from req 0 → c_we high for 4 cycles, then rq_wack[0] and rq_err[0] pulse together; next request is served normally.
- Req 0 drops rq_re one cycle after grant, raddr input changes → read_addr stays latched, rq_rack[0] still pulses.
